level_sequencer: RTL and testbench

Gameplay engine that drives the game-state controller's `level_complete` and `game_over_signal` inputs. While the controller is in LEVEL_INCREMENT (`current_state == 2'b01`), it plays a pseudo-random LED pattern of `current_level + 1` symbols. It then reads the player's switch presses and reports pass or fail as single-cycle pulses. It sits between the state controller and the board LEDs/switches.

---
 rtl/level_sequencer.sv | 158 +++++++++++++++
 tb/tb_level_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_sequencer.sv
// Memory-game sequencer: plays an LFSR-generated LED pattern, then checks the player's presses.
// Optional macro SEQ_TIMEOUT_EN adds a per-symbol input timeout in WAIT.
module level_sequencer #(
  parameter int          STEP_CYCLES    = 12_500_000,
  parameter int          GAP_CYCLES     = 5_000_000,
  parameter int          TIMEOUT_CYCLES = 125_000_000,
  parameter logic [15:0] FIXED_SEED     = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic [3:0] current_level,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic [3:0] led,
  output logic       input_phase,
  output logic       level_complete,
  output logic       game_over_signal
);

  localparam int MAX_A   = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_GAP, S_SHOW, S_ARM, S_WAIT, S_RELEASE, S_PASS, S_FAIL, S_DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] len_clamp(input logic [3:0] lvl);
    return (lvl > 4'd8) ? 4'd9 : lvl + 4'd1;
  endfunction

  state_t               state, state_n;
  logic [15:0]          counter;
  logic [15:0]          seed;
  logic [15:0]          lfsr;
  logic [3:0]           len;
  logic [3:0]           idx;
  logic [TIMER_W-1:0]   timer;
  logic [3:0]           sw_p0, sw_p1, sw_p2;

  logic       active;
  logic       press_vld;
  logic       press_hit;
  logic       idx_last;
  logic       seed_ld, len_ld, lfsr_ld, lfsr_adv, idx_clr, idx_inc;

  assign active    = (current_state == 2'b01);
  // sw_p1 is the synchronized value; sw_p2 is its previous cycle for edge detection
  assign press_vld = (sw_p1 != 4'd0) && ((sw_p1 & (sw_p1 - 4'd1)) == 4'd0) &&
                     ((sw_p1 & sw_p2) == 4'd0);
  assign press_hit = (sw_p1 == (4'b0001 << lfsr[1:0]));
  assign idx_last  = ((idx + 4'd1) == len);

  assign led         = (state == S_SHOW) ? (4'b0001 << lfsr[1:0]) : 4'b0000;
  assign input_phase = (state == S_WAIT) || (state == S_RELEASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    seed_ld  = 1'b0;
    len_ld   = 1'b0;
    lfsr_ld  = 1'b0;
    lfsr_adv = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (active) begin
          state_n = S_LOAD;
          seed_ld = 1'b1;
        end
      end
      S_LOAD: begin
        len_ld  = 1'b1;
        lfsr_ld = 1'b1;
        idx_clr = 1'b1;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (timer == TIMER_W'(GAP_CYCLES - 1)) state_n = S_SHOW;
      end
      S_SHOW: begin
        if (timer == TIMER_W'(STEP_CYCLES - 1)) begin
          lfsr_adv = 1'b1;
          idx_inc  = 1'b1;
          state_n  = idx_last ? S_ARM : S_GAP;
        end
      end
      S_ARM: begin
        lfsr_ld = 1'b1;
        idx_clr = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (press_vld) state_n = press_hit ? S_RELEASE : S_FAIL;
`ifdef SEQ_TIMEOUT_EN
        else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) state_n = S_FAIL;
`endif
      end
      S_RELEASE: begin
        if (sw_p1 == 4'd0) begin
          lfsr_adv = 1'b1;
          idx_inc  = 1'b1;
          state_n  = idx_last ? S_PASS : S_WAIT;
        end
      end
      S_PASS:  state_n = S_DONE;
      S_FAIL:  state_n = S_DONE;
      S_DONE:  if (!active) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Leaving LEVEL_INCREMENT abandons the round silently
    if ((state != S_IDLE) && !active) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter          <= 16'hACE1;
      seed             <= 16'h0000;
      lfsr             <= 16'h0000;
      len              <= 4'd0;
      idx              <= 4'd0;
      timer            <= '0;
      sw_p0            <= 4'd0;
      sw_p1            <= 4'd0;
      sw_p2            <= 4'd0;
      level_complete   <= 1'b0;
      game_over_signal <= 1'b0;
    end else begin
      counter <= counter + 16'd1;
      sw_p0   <= {switch4, switch3, switch2, switch1};
      sw_p1   <= sw_p0;
      sw_p2   <= sw_p1;
      if (seed_ld) seed <= (FIXED_SEED != 16'h0000) ? FIXED_SEED : (counter | 16'h0001);
      if (len_ld)  len  <= len_clamp(current_level);
      if (lfsr_ld)       lfsr <= seed;
      else if (lfsr_adv) lfsr <= lfsr_next(lfsr);
      if (idx_clr)      idx <= 4'd0;
      else if (idx_inc) idx <= idx + 4'd1;
      // Every state change restarts the shared timer
      timer            <= (state_n != state) ? '0 : timer + 1'b1;
      level_complete   <= (state == S_PASS) && active;
      game_over_signal <= (state == S_FAIL) && active;
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with STEP=4, GAP=2, TIMEOUT=20, seed 16'h1D35 (symbols 1,2,1,...).
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] current_state;
  logic [3:0] current_level;
  logic       switch1, switch2, switch3, switch4;
  logic [3:0] led;
  logic       input_phase;
  logic       level_complete;
  logic       game_over_signal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int lc_cnt = 0;
  int go_cnt = 0;
  int shown_cycles = 0;
  int cycles;
  logic [3:0] prev_led = 4'd0;
  logic [3:0] shown[$];

  level_sequencer #(
    .STEP_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(20),
    .FIXED_SEED(16'h1D35)
  ) dut (
    .clk(clk),
    .reset(reset),
    .current_state(current_state),
    .current_level(current_level),
    .switch1(switch1),
    .switch2(switch2),
    .switch3(switch3),
    .switch4(switch4),
    .led(led),
    .input_phase(input_phase),
    .level_complete(level_complete),
    .game_over_signal(game_over_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts high cycles and checks the two pulses never overlap
  always @(negedge clk) begin
    if (level_complete || game_over_signal) begin
      check("pulse_exclusive", {31'd0, level_complete & game_over_signal}, 32'd0);
      if (level_complete)   lc_cnt++;
      if (game_over_signal) go_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (led != 4'd0 && prev_led == 4'd0) shown.push_back(led);
    if (led != 4'd0) shown_cycles++;
    prev_led = led;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_sw(input logic [3:0] m);
    {switch4, switch3, switch2, switch1} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_sw(m);
    tickn(4);
    set_sw(4'd0);
    tickn(4);
  endtask

  task automatic round_start(input logic [3:0] lvl);
    shown.delete();
    shown_cycles  = 0;
    lc_cnt        = 0;
    go_cnt        = 0;
    current_level = lvl;
    current_state = 2'b01;
    start_cyc     = cyc;
  endtask

  task automatic end_round();
    current_state = 2'b00;
    tickn(2);
  endtask

  task automatic wait_phase(input int budget, output int c);
    while (!input_phase && (cyc - start_cyc) < budget) tick();
    c = cyc - start_cyc;
    check("phase_reached", {31'd0, input_phase}, 32'd1);
  endtask

  function automatic logic [31:0] shown_packed();
    logic [31:0] p = 32'd0;
    for (int i = 0; i < shown.size() && i < 8; i++) p = (p << 4) | {28'd0, shown[i]};
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    reset = 1'b1;
    current_state = 2'b00;
    current_level = 4'd0;
    set_sw(4'd0);
    tickn(3);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_phase", {31'd0, input_phase}, 32'd0);
    check("rst_lc", {31'd0, level_complete}, 32'd0);
    check("rst_go", {31'd0, game_over_signal}, 32'd0);
    check("rst_counter", {16'd0, dut.counter}, 32'h0000ACE1);
    reset = 1'b0;
    tickn(3);
    check("idle_led", {28'd0, led}, 32'd0);

    // Level 0: one symbol (switch2), LOAD + 2 gap + 4 show + ARM before WAIT
    round_start(4'd0);
    wait_phase(40, cycles);
    check("l0_latency", cycles, 32'd9);
    check("l0_seq", shown_packed(), 32'h2);
    check("l0_show_cycles", shown_cycles, 32'd4);
    press(4'b0010);
    tickn(2);
    check("l0_lc", lc_cnt, 32'd1);
    check("l0_go", go_cnt, 32'd0);
    check("l0_phase_after", {31'd0, input_phase}, 32'd0);
    end_round();

    // Level 2 with playback press, two-switch and four-switch chords, then correct entry
    round_start(4'd2);
    press(4'b1000);
    wait_phase(60, cycles);
    check("l2_latency", cycles, 32'd21);
    check("l2_seq", shown_packed(), 32'h242);
    check("l2_show_cycles", shown_cycles, 32'd12);
    press(4'b0110);
    check("chord2_phase", {31'd0, input_phase}, 32'd1);
    check("chord2_pulses", lc_cnt + go_cnt, 32'd0);
    press(4'b1111);
    check("chord4_phase", {31'd0, input_phase}, 32'd1);
    check("chord4_pulses", lc_cnt + go_cnt, 32'd0);
    press(4'b0010);
    press(4'b0100);
    check("l2_mid_phase", {31'd0, input_phase}, 32'd1);
    press(4'b0010);
    tickn(2);
    check("l2_lc", lc_cnt, 32'd1);
    check("l2_go", go_cnt, 32'd0);
    end_round();

    // Level 2 with wrong second press, later presses ignored
    round_start(4'd2);
    wait_phase(60, cycles);
    press(4'b0010);
    press(4'b0010);
    tickn(2);
    check("wrong_go", go_cnt, 32'd1);
    check("wrong_lc", lc_cnt, 32'd0);
    check("wrong_phase", {31'd0, input_phase}, 32'd0);
    press(4'b0100);
    tickn(2);
    check("after_fail_go", go_cnt, 32'd1);
    check("after_fail_lc", lc_cnt, 32'd0);
    end_round();

    // Idle player in WAIT
    round_start(4'd0);
    wait_phase(40, cycles);
`ifdef SEQ_TIMEOUT_EN
    tickn(19);
    check("to_before", go_cnt, 32'd0);
    check("to_before_phase", {31'd0, input_phase}, 32'd1);
    tickn(3);
    check("to_go", go_cnt, 32'd1);
    check("to_phase", {31'd0, input_phase}, 32'd0);
`else
    tickn(200);
    check("noto_pulses", lc_cnt + go_cnt, 32'd0);
    check("noto_phase", {31'd0, input_phase}, 32'd1);
`endif
    end_round();

    // Abort mid-playback, then replay from the first symbol
    round_start(4'd1);
    tickn(5);
    check("abort_pre_led", {28'd0, led}, 32'h2);
    current_state = 2'b10;
    tick();
    check("abort_led", {28'd0, led}, 32'd0);
    check("abort_phase", {31'd0, input_phase}, 32'd0);
    tickn(5);
    check("abort_idle_led", {28'd0, led}, 32'd0);
    round_start(4'd1);
    wait_phase(40, cycles);
    check("replay_latency", cycles, 32'd15);
    check("replay_seq", shown_packed(), 32'h24);
    check("abort_pulses", lc_cnt + go_cnt, 32'd0);

    // Asynchronous reset while in RELEASE
    set_sw(4'b0010);
    tickn(4);
    check("rel_phase", {31'd0, input_phase}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_phase", {31'd0, input_phase}, 32'd0);
    check("arst_led", {28'd0, led}, 32'd0);
    check("arst_pulses", {30'd0, level_complete, game_over_signal}, 32'd0);
    check("arst_counter", {16'd0, dut.counter}, 32'h0000ACE1);
    set_sw(4'd0);
    current_state = 2'b00;
    tick();
    reset = 1'b0;
    tickn(6);
    check("post_rst_led", {28'd0, led}, 32'd0);
    check("post_rst_phase", {31'd0, input_phase}, 32'd0);
    round_start(4'd0);
    wait_phase(40, cycles);
    check("post_rst_latency", cycles, 32'd9);
    check("post_rst_seq", shown_packed(), 32'h2);
    end_round();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
